vga_reg_ctrl: RTL and testbench

VGA_REG_CTRL -- requirements
Module: vga_reg_ctrl

---
 rtl/vga_reg_ctrl.sv | 136 +++++++++++++
 tb/tb_vga_reg_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_reg_ctrl.sv
// vga_reg_ctrl: dual-master (CPU / SPU) write port onto three display
// registers. Writes land in shadow registers; vga_data_1..3 either follow the
// shadows at once (commit_mode=0) or are copied from them on the next vertical
// sync rising edge (commit_mode=1).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cpu_req/addr/wdata   CPU write request (held until cpu_ack)
//   cpu_ack              one-cycle CPU acknowledge
//   spu_req/addr/wdata   SPU write request (held until spu_ack)
//   spu_ack              one-cycle SPU acknowledge
//   frame_sync           vertical-sync level, synchronous to clk
//   commit_mode          0 = immediate, 1 = frame-synchronous update
//   vga_data_1..3        committed display words
//   pending              shadows hold uncommitted data
//   err_addr             pulse with an ack whose address matched no register
//   commit_cnt           number of frame commits performed (wraps)
module vga_reg_ctrl #(
    parameter logic [31:0] VGA_BASE = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        spu_req,
    input  logic [31:0] spu_addr,
    input  logic [31:0] spu_wdata,
    output logic        spu_ack,
    input  logic        frame_sync,
    input  logic        commit_mode,
    output logic [31:0] vga_data_1,
    output logic [31:0] vga_data_2,
    output logic [31:0] vga_data_3,
    output logic        pending,
    output logic        err_addr,
    output logic [15:0] commit_cnt
);

    typedef enum logic [1:0] {CLEAN, DIRTY, COMMIT} state_t;

    state_t      state, state_nxt;
    logic        last_spu;      // 1 when the SPU won the most recent grant
    logic        fs_prev;
    logic [31:0] shadow [3];
    logic [31:0] vga_q  [3];

    logic        cpu_elig, spu_elig, grant_cpu, grant_spu, granted;
    logic [31:0] wr_addr, wr_data, wr_off;
    logic [2:0]  wr_sel;
    logic        wr_hit, fs_rise, commit_copy;

    // An acked requester is still holding req during its ack cycle; masking
    // it here keeps the same request from being granted twice.
    always_comb begin
        cpu_elig  = cpu_req & ~cpu_ack;
        spu_elig  = spu_req & ~spu_ack;
        grant_cpu = cpu_elig & (~spu_elig | last_spu);
        grant_spu = spu_elig & ~grant_cpu;
        granted   = grant_cpu | grant_spu;
        wr_addr   = grant_cpu ? cpu_addr  : spu_addr;
        wr_data   = grant_cpu ? cpu_wdata : spu_wdata;
        wr_off    = wr_addr - VGA_BASE;
        wr_sel[0] = granted & (wr_off == 32'd0);
        wr_sel[1] = granted & (wr_off == 32'd4);
        wr_sel[2] = granted & (wr_off == 32'd8);
        wr_hit    = |wr_sel;
        fs_rise   = frame_sync & ~fs_prev;
    end

    always_comb begin
        state_nxt   = state;
        commit_copy = 1'b0;
        case (state)
            CLEAN: begin
                if (wr_hit && commit_mode)
                    state_nxt = DIRTY;
            end
            DIRTY: begin
                // Leaving frame-synchronous mode flushes without waiting for sync.
                if (fs_rise || !commit_mode)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                commit_copy = 1'b1;
                // A write landing on the copy edge is not in the copied values,
                // so it leaves fresh uncommitted data behind.
                state_nxt   = (wr_hit && commit_mode) ? DIRTY : CLEAN;
            end
            default: state_nxt = CLEAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAN;
            last_spu   <= 1'b1;
            fs_prev    <= 1'b0;
            cpu_ack    <= 1'b0;
            spu_ack    <= 1'b0;
            err_addr   <= 1'b0;
            commit_cnt <= 16'h0000;
            for (int k = 0; k < 3; k++) begin
                shadow[k] <= 32'h0;
                vga_q[k]  <= 32'h0;
            end
        end else begin
            state    <= state_nxt;
            fs_prev  <= frame_sync;
            cpu_ack  <= grant_cpu;
            spu_ack  <= grant_spu;
            err_addr <= granted & ~wr_hit;
            if (granted)
                last_spu <= grant_spu;
            if (commit_copy)
                commit_cnt <= commit_cnt + 16'd1;
            for (int k = 0; k < 3; k++) begin
                // Copy first; an immediate-mode write to the same word wins.
                if (commit_copy)
                    vga_q[k] <= shadow[k];
                if (wr_sel[k]) begin
                    shadow[k] <= wr_data;
                    if (!commit_mode)
                        vga_q[k] <= wr_data;
                end
            end
        end
    end

    assign pending    = (state != CLEAN);
    assign vga_data_1 = vga_q[0];
    assign vga_data_2 = vga_q[1];
    assign vga_data_3 = vga_q[2];

endmodule

// File: tb/tb_vga_reg_ctrl.sv
module tb_vga_reg_ctrl;

    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        creq, sreq, fs, mode;
    logic [31:0] caddr, cdata, saddr, sdata;
    logic        cack, sack, pend, err;
    logic [31:0] vd1, vd2, vd3;
    logic [15:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] m_sh [3];
    logic [31:0] m_vd [3];
    bit          m_cack, m_sack, m_err, m_dirty, m_copy, m_fs_prev;
    int          m_last;   // 0 none, 1 cpu, 2 spu
    int          m_cnt;

    vga_reg_ctrl #(.VGA_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(creq), .cpu_addr(caddr), .cpu_wdata(cdata), .cpu_ack(cack),
        .spu_req(sreq), .spu_addr(saddr), .spu_wdata(sdata), .spu_ack(sack),
        .frame_sync(fs), .commit_mode(mode),
        .vga_data_1(vd1), .vga_data_2(vd2), .vga_data_3(vd3),
        .pending(pend), .err_addr(err), .commit_cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sh[k] = 32'h0;
            m_vd[k] = 32'h0;
        end
        m_cack = 0; m_sack = 0; m_err = 0; m_dirty = 0; m_copy = 0;
        m_fs_prev = 0; m_last = 0; m_cnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit ec, es, gc, gs, hit, rise, nxt_copy;
        logic [31:0] a, d, off;
        int idx;
        ec = creq && !m_cack;
        es = sreq && !m_sack;
        gc = ec && !(es && m_last == 1);
        gs = es && !gc;
        a  = gc ? caddr : saddr;
        d  = gc ? cdata : sdata;
        off = a - BASE;
        hit = (gc || gs) && (off == 0 || off == 4 || off == 8);
        idx = int'(off / 4);
        rise = fs && !m_fs_prev;
        nxt_copy = m_dirty && (rise || !mode);
        if (m_copy) begin
            for (int k = 0; k < 3; k++) m_vd[k] = m_sh[k];
            m_cnt = (m_cnt + 1) % 65536;
        end
        if (hit) begin
            if (!mode) m_vd[idx] = d;
            m_sh[idx] = d;
        end
        m_dirty = nxt_copy ? 1'b0 : (m_dirty || (hit && mode));
        m_copy  = nxt_copy;
        m_cack  = gc;
        m_sack  = gs;
        m_err   = (gc || gs) && !hit;
        if (gc) m_last = 1;
        else if (gs) m_last = 2;
        m_fs_prev = fs;
    endtask

    task automatic check_all();
        check_eq("cpu_ack", {31'b0, cack}, {31'b0, m_cack});
        check_eq("spu_ack", {31'b0, sack}, {31'b0, m_sack});
        check_eq("err_addr", {31'b0, err}, {31'b0, m_err});
        check_eq("pending", {31'b0, pend}, {31'b0, m_dirty || m_copy});
        check_eq("vga_data_1", vd1, m_vd[0]);
        check_eq("vga_data_2", vd2, m_vd[1]);
        check_eq("vga_data_3", vd3, m_vd[2]);
        check_eq("commit_cnt", {16'b0, cnt}, m_cnt[31:0]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        creq = 0; sreq = 0; fs = 0;
        rst = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // Issue one write and hold req until the model says it was acked.
    task automatic do_write(input bit use_spu, input logic [31:0] a, input logic [31:0] d);
        bit done = 0;
        if (use_spu) begin sreq = 1; saddr = a; sdata = d; end
        else         begin creq = 1; caddr = a; cdata = d; end
        for (int i = 0; i < 8 && !done; i++) begin
            tick();
            done = use_spu ? m_sack : m_cack;
        end
        if (use_spu) sreq = 0; else creq = 0;
        if (!done) check_eq("write_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        if ($urandom_range(0, 9) < 8) r = BASE + 32'($urandom_range(0, 2) * 4);
        else r = BASE + 32'($urandom_range(3, 40) * 4) + 32'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        rst = 1; creq = 0; sreq = 0; fs = 0; mode = 0;
        caddr = 0; cdata = 0; saddr = 0; sdata = 0;
        model_reset();
        #2;
        check_eq("reset_vd1", vd1, 32'h0);
        check_eq("reset_pending", {31'b0, pend}, 32'h0);
        apply_reset();

        // immediate write
        mode = 0;
        do_write(0, BASE + 4, 32'hDEADBEEF);
        check_eq("imm_ack", {31'b0, cack}, 32'h1);
        check_eq("imm_vd2", vd2, 32'hDEADBEEF);
        check_eq("imm_pending", {31'b0, pend}, 32'h0);

        // bad address
        do_write(0, BASE + 12, 32'h1234_5678);
        check_eq("bad_ack", {31'b0, cack}, 32'h1);
        check_eq("bad_err", {31'b0, err}, 32'h1);
        check_eq("bad_vd1", vd1, 32'h0);
        check_eq("bad_vd2", vd2, 32'hDEADBEEF);
        check_eq("bad_vd3", vd3, 32'h0);
        tick();
        check_eq("bad_err_clear", {31'b0, err}, 32'h0);

        // contention right after reset
        apply_reset();
        mode = 0;
        creq = 1; caddr = BASE;     cdata = 32'hAAAA_0001;
        sreq = 1; saddr = BASE + 8; sdata = 32'h5555_0003;
        tick();
        check_eq("cont_cpu_first", {31'b0, cack}, 32'h1);
        check_eq("cont_spu_wait", {31'b0, sack}, 32'h0);
        creq = 0;
        tick();
        check_eq("cont_spu_second", {31'b0, sack}, 32'h1);
        sreq = 0;
        check_eq("cont_vd1", vd1, 32'hAAAA_0001);
        check_eq("cont_vd3", vd3, 32'h5555_0003);

        // deferred commit
        apply_reset();
        mode = 1;
        do_write(1, BASE, 32'h00FF00FF);
        check_eq("def_ack", {31'b0, sack}, 32'h1);
        check_eq("def_vd1_hold", vd1, 32'h0);
        check_eq("def_pending", {31'b0, pend}, 32'h1);
        tick(); tick();
        check_eq("def_vd1_wait", vd1, 32'h0);
        fs = 1;
        tick();
        check_eq("def_vd1_edge1", vd1, 32'h0);
        tick();
        check_eq("def_vd1_commit", vd1, 32'h00FF00FF);
        check_eq("def_cnt", {16'b0, cnt}, 32'd1);
        check_eq("def_pending_clr", {31'b0, pend}, 32'h0);
        fs = 0;
        tick();

        // write landing on the edge that leaves COMMIT
        do_write(0, BASE + 8, 32'h0000_000B);
        fs = 1;
        tick();
        check_eq("wc_pending_commit", {31'b0, pend}, 32'h1);
        creq = 1; caddr = BASE + 8; cdata = 32'h0000_000C;
        tick();
        creq = 0;
        check_eq("wc_ack", {31'b0, cack}, 32'h1);
        check_eq("wc_vd3_old", vd3, 32'h0000_000B);
        check_eq("wc_dirty", {31'b0, pend}, 32'h1);
        fs = 0;
        tick(); tick();
        check_eq("wc_vd3_hold", vd3, 32'h0000_000B);
        fs = 1;
        tick(); tick();
        check_eq("wc_vd3_new", vd3, 32'h0000_000C);
        check_eq("wc_pending_clr", {31'b0, pend}, 32'h0);
        fs = 0;

        // reset while DIRTY with nonzero outputs
        do_write(1, BASE + 4, 32'h7777_7777);
        check_eq("rm_pending", {31'b0, pend}, 32'h1);
        rst = 1;
        #1;
        check_eq("rm_vd1", vd1, 32'h0);
        check_eq("rm_vd3", vd3, 32'h0);
        check_eq("rm_pending0", {31'b0, pend}, 32'h0);
        check_eq("rm_cnt", {16'b0, cnt}, 32'h0);
        #1;
        apply_reset();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (creq && m_cack) creq = 0;
            else if (!creq && $urandom_range(0, 2) == 0) begin
                creq = 1; caddr = rand_addr(); cdata = $urandom;
            end
            if (sreq && m_sack) sreq = 0;
            else if (!sreq && $urandom_range(0, 2) == 0) begin
                sreq = 1; saddr = rand_addr(); sdata = $urandom;
            end
            if ($urandom_range(0, 7) == 0) fs = ~fs;
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
